// File: rtl/calc_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calc_alu_seq
// Purpose  : Multi-cycle arithmetic sequencer for the 8-digit calculator.
//            One shared shift/add datapath steps through add/sub/mul/div and
//            then a double-dabble binary-to-BCD conversion.
// Revision : 1.0 - initial release
// ============================================================================
module calc_alu_seq #(
  parameter int W      = 27,
  parameter int DIGITS = 8,
  parameter int MAXVAL = 99999999
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [W-1:0]          i_a,
  input  logic [W-1:0]          i_b,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd8d,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int                CW        = $clog2(W);
  localparam logic [CW-1:0]     c_last    = CW'(W - 1);
  localparam logic [W-1:0]      c_max_w   = W'(MAXVAL);
  localparam logic [2*W-1:0]    c_max_2w  = (2*W)'(MAXVAL);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [W-1:0]          r_a, r_b;
  logic [1:0]            r_op;
  logic                  r_first;
  logic [CW-1:0]         r_cnt;
  logic [2*W-1:0]        r_acc;      // product / {remainder, quotient} / binary shifter
  logic [4*DIGITS-1:0]   r_bcd;
  logic [4*DIGITS-1:0]   r_out_bcd;
  logic                  r_err;
  logic [1:0]            r_code;

  logic [1:0]            w_op_code;
  logic [2*W-1:0]        w_mul, w_div, w_res;
  logic                  w_ge;
  logic [W-1:0]          w_diff;
  logic                  w_calc_end, w_ovf;
  logic [4*DIGITS-1:0]   w_adj, w_bcd_next;

  // Operand validity check, evaluated during the first CALC cycle
  always_comb begin
    w_op_code = 2'd0;
    if (r_a > c_max_w || r_b > c_max_w)  w_op_code = 2'd1;
    else if (r_op == 2'd0 && r_b == '0)  w_op_code = 2'd3;
    else if (r_op == 2'd2 && r_a < r_b)  w_op_code = 2'd2;
  end

  // Shared datapath: one shift-add (MSB-first multiplier) or one restoring
  // divide step per cycle, plus the final result select and overflow test
  always_comb begin
    w_mul  = {r_acc[2*W-2:0], 1'b0} + (r_b[W-1] ? (2*W)'(r_a) : '0);
    // Shifted partial remainder needs W+1 bits: remainder can exceed 2^(W-1)
    w_ge   = (r_acc[2*W-1:W-1] >= {1'b0, r_b});
    w_diff = r_acc[2*W-2:W-1] - r_b;
    w_div  = w_ge ? {w_diff, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};
    case (r_op)
      2'd0:    w_res = {{W{1'b0}}, w_div[W-1:0]};
      2'd1:    w_res = w_mul;
      2'd2:    w_res = (2*W)'(r_a - r_b);
      default: w_res = (2*W)'(r_a) + (2*W)'(r_b);
    endcase
    w_calc_end = r_op[1] | (r_cnt == c_last);
    w_ovf      = (w_res > c_max_2w);
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift in next bit
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_adj[4*DIGITS-2:0], r_acc[W-1]};
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_CALC;
      S_CALC: begin
        if (r_first) begin
          if (w_op_code != 2'd0) w_next = S_DONE;
        end else if (w_calc_end) begin
          w_next = w_ovf ? S_DONE : S_CONV;
        end
      end
      S_CONV: if (r_cnt == c_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // Datapath and result registers; nothing updates on an aborted cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_first   <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_bcd     <= '0;
      r_out_bcd <= '0;
      r_err     <= 1'b0;
      r_code    <= '0;
    end else if (!i_abort) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= i_op;
            r_first <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          if (r_first) begin
            if (w_op_code != 2'd0) begin
              r_out_bcd <= '0;
              r_err     <= 1'b1;
              r_code    <= w_op_code;
            end else begin
              r_first <= 1'b0;
              r_cnt   <= '0;
              r_acc   <= (r_op == 2'd0) ? (2*W)'(r_a) : '0;
            end
          end else begin
            if (r_op == 2'd1) begin
              r_acc <= w_mul;
              r_b   <= {r_b[W-2:0], 1'b0};
            end else if (r_op == 2'd0) begin
              r_acc <= w_div;
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_calc_end) begin
              if (w_ovf) begin
                r_out_bcd <= '0;
                r_err     <= 1'b1;
                r_code    <= 2'd1;
              end else begin
                r_acc <= {{W{1'b0}}, w_res[W-1:0]};
                r_bcd <= '0;
                r_cnt <= '0;
              end
            end
          end
        end
        S_CONV: begin
          r_bcd          <= w_bcd_next;
          r_acc[W-1:0]   <= {r_acc[W-2:0], 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_out_bcd <= w_bcd_next;
            r_err     <= 1'b0;
            r_code    <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_bcd8d    = r_out_bcd;
  assign o_err      = r_err;
  assign o_err_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_calc_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_calc_alu_seq
// Purpose  : Self-checking bench for calc_alu_seq. An arithmetic model gives
//            result, error code and latency; a per-cycle compare process
//            checks every output against the expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_alu_seq;

  localparam int     W      = 27;
  localparam int     DIGITS = 8;
  localparam longint MAXVAL = 99999999;

  logic          i_clk = 1'b0;
  logic          i_rstn, i_start, i_abort;
  logic [1:0]    i_op;
  logic [W-1:0]  i_a, i_b;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_bcd8d;
  logic [1:0]    o_err_code;

  calc_alu_seq #(.W(W), .DIGITS(DIGITS), .MAXVAL(99999999)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_abort(i_abort), .o_busy(o_busy),
    .o_done(o_done), .o_bcd8d(o_bcd8d), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Expected output values, maintained by the stimulus from the model
  logic        m_busy, m_done, m_err;
  logic [1:0]  m_code;
  logic [31:0] m_bcd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare process: every output checked on every falling edge
  always @(negedge i_clk) begin
    chk("busy",  32'(o_busy),     32'(m_busy));
    chk("done",  32'(o_done),     32'(m_done));
    chk("bcd",   o_bcd8d,         m_bcd);
    chk("err",   32'(o_err),      32'(m_err));
    chk("code",  32'(o_err_code), 32'(m_code));
  end

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Behavioural model: result, error code and cycles from start edge to done
  task automatic model(input int op, input longint a, input longint b,
                       output logic [31:0] bcd, output logic [1:0] code, output int lat);
    longint r;
    int     calc_len;
    code = 2'd0;
    r    = 0;
    if (a > MAXVAL || b > MAXVAL)  begin code = 2'd1; lat = 2; end
    else if (op == 0 && b == 0)    begin code = 2'd3; lat = 2; end
    else if (op == 2 && a < b)     begin code = 2'd2; lat = 2; end
    else begin
      case (op)
        0: r = a / b;
        1: r = a * b;
        2: r = a - b;
        default: r = a + b;
      endcase
      calc_len = (op >= 2) ? 1 : W;
      if (r > MAXVAL) begin code = 2'd1; lat = calc_len + 2; end
      else lat = calc_len + W + 2;
    end
    bcd = (code != 2'd0) ? 32'h0 : to_bcd(r);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Full operation: also scrambles operands and pulses start while busy
  task automatic run_op(input int op, input longint a, input longint b);
    logic [31:0] ebcd;
    logic [1:0]  ecode;
    int          lat;
    model(op, a, b, ebcd, ecode, lat);
    i_op = 2'(op); i_a = W'(a); i_b = W'(b); i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      m_busy = 1'b1;
      m_done = (k == lat);
      if (k == lat) begin
        m_bcd = ebcd; m_code = ecode; m_err = (ecode != 2'd0);
      end
      if (k == 3) begin
        i_a = W'($urandom); i_b = W'($urandom); i_op = 2'($urandom);
      end
      i_start = (k == 5 && k < lat - 1);
      step();
    end
    i_start = 1'b0;
    m_busy = 1'b0; m_done = 1'b0;
  endtask

  logic [31:0] t_bcd;
  logic [1:0]  t_code;
  int          t_lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Hand-computed pins on the model itself
    model(3, 12345678, 87654321, t_bcd, t_code, t_lat);
    chk("pin_add_bcd", t_bcd, 32'h99999999);  chk("pin_add_lat", 32'(t_lat), 32'd30);
    model(1, 10000, 10000, t_bcd, t_code, t_lat);
    chk("pin_mulovf_code", 32'(t_code), 32'd1); chk("pin_mulovf_lat", 32'(t_lat), 32'd29);
    model(1, 9999, 9999, t_bcd, t_code, t_lat);
    chk("pin_mul_bcd", t_bcd, 32'h99980001);  chk("pin_mul_lat", 32'(t_lat), 32'd56);
    model(0, 100, 7, t_bcd, t_code, t_lat);
    chk("pin_div_bcd", t_bcd, 32'h00000014);
    model(0, 100, 0, t_bcd, t_code, t_lat);
    chk("pin_div0_code", 32'(t_code), 32'd3); chk("pin_div0_lat", 32'(t_lat), 32'd2);
    model(2, 5, 9, t_bcd, t_code, t_lat);
    chk("pin_neg_code", 32'(t_code), 32'd2);

    // Reset
    i_rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_code = '0; m_bcd = '0;
    step(); step();
    chk("reset_bcd", o_bcd8d, 32'h0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    i_rstn = 1'b1;
    step();

    // Directed operations
    run_op(3, 12345678, 87654321);
    chk("add_lit", o_bcd8d, 32'h99999999);
    run_op(1, 10000, 10000);
    chk("mulovf_lit_err", 32'(o_err), 32'd1);
    run_op(1, 9999, 9999);
    chk("mul_lit", o_bcd8d, 32'h99980001);
    run_op(0, 100, 7);
    chk("div_lit", o_bcd8d, 32'h00000014);
    run_op(0, 100, 0);
    run_op(2, 5, 9);
    run_op(2, 9, 5);
    chk("sub_lit", o_bcd8d, 32'h00000004);
    run_op(3, 100000000, 1);          // operand above MAXVAL
    run_op(3, 99999999, 1);           // add overflow
    run_op(1, 99999999, 1);           // mul at the boundary
    run_op(0, 99999999, 3);
    run_op(0, 99999999, 99999998);    // remainder near 2^27
    run_op(3, 0, 0);

    // Abort a multiply after edge 10: idle after edge 11, outputs kept
    i_op = 2'd1; i_a = W'(1234); i_b = W'(5678); i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      m_busy = 1'b1; m_done = 1'b0;
      i_abort = (k == 10);
      step();
    end
    i_abort = 1'b0; m_busy = 1'b0;
    repeat (3) step();

    // Start and abort together in IDLE: start dropped
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    repeat (3) step();

    // Asynchronous reset in the middle of the conversion
    i_op = 2'd3; i_a = W'(12); i_b = W'(34); i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      m_busy = 1'b1;
      step();
    end
    #2;
    i_rstn = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_code = '0; m_bcd = '0;
    #1;
    chk("rst_async_busy", 32'(o_busy), 32'd0);
    chk("rst_async_bcd", o_bcd8d, 32'h0);
    step(); step();
    i_rstn = 1'b1;
    step();
    run_op(3, 1, 1);
    chk("add11_lit", o_bcd8d, 32'h00000002);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
